// File: rtl/video_wr_packer_if.sv
// Write-side bus between the video packer and the DDR write arbiter.
//
// Handshake semantics:
//   Request: the master raises wr_req with wr_addr/wr_len stable and holds
//   them until the slave pulses wr_ack for exactly one cycle. The request is
//   accepted on the rising edge where wr_req & wr_ack. The master drops
//   wr_req on the following cycle.
//   Data: a word moves on every rising edge where wr_valid & wr_ready. The
//   master never changes wr_data while wr_valid is high and the word has not
//   yet been accepted. wr_valid is only raised between an accepted request
//   and its wr_len-th accepted word.
interface video_wr_packer_if #(
    parameter int ADDR_W = 28
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_len;
    logic              wr_ack;
    logic              wr_valid;
    logic [127:0]      wr_data;
    logic              wr_ready;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_len,
        input  wr_ack,
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_len,
        output wr_ack,
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/video_wr_packer.sv
// Video write packer: converts the scaled RGB888 pixel stream to RGB565,
// packs 8 pixels per 128-bit word, buffers words in a show-ahead FIFO and
// issues burst writes to the DDR write arbiter. A rising vs_in flushes the
// remaining words of the frame, then rewinds the write address to
// FRAME_BASE and pulses frame_done.
module video_wr_packer #(
    parameter int                ADDR_W     = 28,
    parameter logic [ADDR_W-1:0] FRAME_BASE = '0,
    parameter int                BURST_LEN  = 16,
    parameter int                FIFO_DEPTH = 64
) (
    input  logic              pixclk_in,
    input  logic              rst_n,
    input  logic              vs_in,
    input  logic              de_in,
    input  logic [23:0]       data_in,
    video_wr_packer_if.master wr_bus,
    output logic              frame_done,
    output logic              overflow,
    output logic [1:0]        state_dbg
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input edge detection
    // ------------------------------------------------------------------
    logic vs_1d;
    logic de_in_1d;
    logic vs_rise;
    logic de_fall;

    assign vs_rise = vs_in & ~vs_1d;
    assign de_fall = de_in_1d & ~de_in;

    // Delay vs/de by one cycle to find frame and line boundaries.
    always_ff @(posedge pixclk_in or negedge rst_n) begin
        if (!rst_n) begin
            vs_1d    <= 1'b0;
            de_in_1d <= 1'b0;
        end else begin
            vs_1d    <= vs_in;
            de_in_1d <= de_in;
        end
    end

    // ------------------------------------------------------------------
    // RGB565 conversion and 8-pixel packing
    // ------------------------------------------------------------------
    logic [15:0]  pix565;
    logic [127:0] word_buf;
    logic [127:0] word_with_pix;
    logic [127:0] push_word;
    logic         push_valid;
    logic [2:0]   idx;
    logic         unused_bits;

    assign pix565      = {data_in[23:19], data_in[15:10], data_in[7:3]};
    assign unused_bits = ^{data_in[18:16], data_in[9:8], data_in[2:0]};

    // Current word with the incoming pixel dropped into its slot.
    always_comb begin
        word_with_pix = word_buf;
        word_with_pix[{idx, 4'b0000} +: 16] = pix565;
    end

    // Collect pixels; a finished or flushed word is staged in push_word and
    // enters the FIFO one cycle later, so the next line can start at once.
    always_ff @(posedge pixclk_in or negedge rst_n) begin
        if (!rst_n) begin
            word_buf   <= '0;
            push_word  <= '0;
            push_valid <= 1'b0;
            idx        <= 3'd0;
        end else begin
            push_valid <= 1'b0;
            if (de_in) begin
                if (idx == 3'd7) begin
                    push_word  <= word_with_pix;
                    push_valid <= 1'b1;
                    word_buf   <= '0;
                    idx        <= 3'd0;
                end else begin
                    word_buf <= word_with_pix;
                    idx      <= idx + 3'd1;
                end
            end else if ((de_fall || vs_rise) && (idx != 3'd0)) begin
                // Partial word: unused slots are already zero.
                push_word  <= word_buf;
                push_valid <= 1'b1;
                word_buf   <= '0;
                idx        <= 3'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic [127:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_ok;
    logic             pop;
    logic             wr_valid_int;
    logic             overflow_q;

    assign fifo_full  = (fifo_count == DEPTH_CNT);
    assign fifo_empty = (fifo_count == '0);
    assign pop        = wr_valid_int & wr_bus.wr_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still lands.
    assign push_ok    = push_valid & (~fifo_full | pop);

    // Word storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge pixclk_in) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge pixclk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (vs_rise) begin
                overflow_q <= 1'b0;
            end
            if (push_valid && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Burst control FSM
    // ------------------------------------------------------------------
    state_t            state_q;
    logic              wr_req_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_len_q;
    logic [7:0]        beat_q;
    logic              pending_q;
    logic              frame_done_q;

    // Full bursts win over the end-of-frame flush. The flush decision waits
    // while a staged word is still on its way into the FIFO so that a
    // just-flushed partial word is never left behind.
    always_ff @(posedge pixclk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= FRAME_BASE;
            wr_len_q     <= 8'd0;
            beat_q       <= 8'd0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fifo_count >= BURST_CNT) begin
                        wr_len_q <= 8'(BURST_LEN);
                        wr_req_q <= 1'b1;
                        state_q  <= REQ;
                    end else if (pending_q && !push_valid) begin
                        if (!fifo_empty) begin
                            wr_len_q <= 8'(fifo_count);
                            wr_req_q <= 1'b1;
                            state_q  <= REQ;
                        end else begin
                            wr_addr_q    <= FRAME_BASE;
                            pending_q    <= 1'b0;
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (wr_bus.wr_ack) begin
                        wr_req_q <= 1'b0;
                        beat_q   <= 8'd0;
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (pop) begin
                        beat_q <= beat_q + 8'd1;
                        if ((beat_q + 8'd1) == wr_len_q) begin
                            wr_addr_q <= wr_addr_q + ADDR_W'({wr_len_q, 4'b0000});
                            state_q   <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (vs_rise) begin
                pending_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_valid_int    = (state_q == DATA) && !fifo_empty;
    assign wr_bus.wr_valid = wr_valid_int;
    assign wr_bus.wr_data  = wr_valid_int ? fifo_mem[rd_ptr] : '0;
    assign wr_bus.wr_req   = wr_req_q;
    assign wr_bus.wr_addr  = wr_addr_q;
    assign wr_bus.wr_len   = wr_len_q;
    assign frame_done      = frame_done_q;
    assign overflow        = overflow_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_video_wr_packer.sv
// Bench for video_wr_packer: random pixel frames against a frame-level
// model (pixels -> RGB565 words, words -> bursts of 16 plus remainder at
// consecutive addresses from FRAME_BASE), with a bus responder that
// acknowledges requests and scoreboards every accepted word.
module tb_video_wr_packer;
  localparam int ADDR_W = 28;
  localparam logic [ADDR_W-1:0] FRAME_BASE = 28'h000_0000;
  localparam int W = 128;

  logic        pixclk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs_in = 1'b0;
  logic        de_in = 1'b0;
  logic [23:0] data_in = 24'd0;
  logic        frame_done;
  logic        overflow;
  logic [1:0]  state_dbg;

  video_wr_packer_if #(.ADDR_W(ADDR_W)) bus ();

  video_wr_packer #(
    .ADDR_W(ADDR_W),
    .FRAME_BASE(FRAME_BASE),
    .BURST_LEN(16),
    .FIFO_DEPTH(64)
  ) dut (
    .pixclk_in(pixclk_in),
    .rst_n(rst_n),
    .vs_in(vs_in),
    .de_in(de_in),
    .data_in(data_in),
    .wr_bus(bus),
    .frame_done(frame_done),
    .overflow(overflow),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 pixclk_in = ~pixclk_in;

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [W-1:0]      exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [7:0]        exp_len_q[$];
  logic [23:0]       pix_q[$];
  int                line_len_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int beats_left = 0;
  int fd_cnt = 0;
  int ack_cnt = 0;
  int ack_delay = 2;
  int ready_mode = 0;
  bit ack_enable = 1'b1;
  logic [W-1:0]      last_beat = '0;
  logic [ADDR_W-1:0] last_ack_addr = '0;
  logic [7:0]        last_ack_len = '0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to565(input logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction

  // bus responder and beat monitor (acts at negedges, applies at next posedge)
  initial begin
    bus.wr_ack = 1'b0;
    bus.wr_ready = 1'b0;
    forever begin
      @(negedge pixclk_in);
      if (!rst_n) begin
        bus.wr_ack = 1'b0;
        ack_cnt = 0;
        beats_left = 0;
      end else begin
        if (frame_done) fd_cnt++;
        case (ready_mode)
          0: bus.wr_ready = 1'b1;
          1: bus.wr_ready = ~bus.wr_ready;
          default: bus.wr_ready = 1'($urandom_range(0, 1));
        endcase
        if (bus.wr_valid) begin
          check("valid_in_burst", W'(beats_left != 0), W'(1));
          if (bus.wr_ready) begin
            check("beat_expected", W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0) check("beat_data", bus.wr_data, exp_q.pop_front());
            last_beat = bus.wr_data;
            if (beats_left > 0) beats_left--;
          end
        end
        if (bus.wr_ack) begin
          bus.wr_ack = 1'b0;
        end else if (bus.wr_req && ack_enable) begin
          ack_cnt++;
          if (ack_cnt >= ack_delay) begin
            bus.wr_ack = 1'b1;
            ack_cnt = 0;
            last_ack_addr = bus.wr_addr;
            last_ack_len = bus.wr_len;
            beats_left = int'(bus.wr_len);
            check("burst_expected", W'(exp_len_q.size() != 0), W'(1));
            if (exp_len_q.size() != 0) begin
              check("burst_addr", W'(bus.wr_addr), W'(exp_addr_q.pop_front()));
              check("burst_len", W'(bus.wr_len), W'(exp_len_q.pop_front()));
            end
          end
        end
      end
    end
  end

  // reference model: plan a frame from line_len_q
  task automatic plan_frame(input bit ones, input int max_words);
    int words;
    int kept;
    logic [W-1:0] cur;
    logic [23:0] p;
    words = 0;
    foreach (line_len_q[l]) begin
      cur = '0;
      for (int i = 0; i < line_len_q[l]; i++) begin
        p = ones ? 24'hFFFFFF : 24'($urandom);
        pix_q.push_back(p);
        cur[16 * (i % 8) +: 16] = to565(p);
        if ((i % 8 == 7) || (i == line_len_q[l] - 1)) begin
          if (words < max_words) exp_q.push_back(cur);
          words++;
          cur = '0;
        end
      end
    end
    kept = (words < max_words) ? words : max_words;
    for (int b = 0; b < kept / 16; b++) begin
      exp_addr_q.push_back(FRAME_BASE + ADDR_W'(b * 256));
      exp_len_q.push_back(8'd16);
    end
    if (kept % 16 != 0) begin
      exp_addr_q.push_back(FRAME_BASE + ADDR_W'((kept / 16) * 256));
      exp_len_q.push_back(8'(kept % 16));
    end
  endtask

  // driver tasks
  task automatic drive_line(input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      @(negedge pixclk_in);
      de_in = 1'b1;
      data_in = pix_q.pop_front();
    end
    @(negedge pixclk_in);
    de_in = 1'b0;
    data_in = 24'($urandom);
    repeat (gap) @(negedge pixclk_in);
  endtask

  task automatic drive_frame_lines();
    while (line_len_q.size() != 0) drive_line(line_len_q.pop_front(), $urandom_range(4, 20));
  endtask

  task automatic wait_fd(input int target);
    for (int c = 0; c < 20000 && fd_cnt < target; c++) @(negedge pixclk_in);
    check("frame_done_count", W'(fd_cnt), W'(target));
  endtask

  task automatic send_vs_wait();
    int target;
    target = fd_cnt + 1;
    @(negedge pixclk_in);
    vs_in = 1'b1;
    repeat (2) @(negedge pixclk_in);
    vs_in = 1'b0;
    wait_fd(target);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_words_left"}, W'(exp_q.size()), W'(0));
    check({tag, "_bursts_left"}, W'(exp_len_q.size()), W'(0));
  endtask

  task automatic run_frame(input bit ones);
    send_vs_wait();
    plan_frame(ones, 1 << 20);
    drive_frame_lines();
    send_vs_wait();
    check_drained("frame");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_req"}, W'(bus.wr_req), W'(0));
    check({tag, "_wr_addr"}, W'(bus.wr_addr), W'(FRAME_BASE));
    check({tag, "_wr_len"}, W'(bus.wr_len), W'(0));
    check({tag, "_wr_valid"}, W'(bus.wr_valid), W'(0));
    check({tag, "_wr_data"}, bus.wr_data, W'(0));
    check({tag, "_frame_done"}, W'(frame_done), W'(0));
    check({tag, "_overflow"}, W'(overflow), W'(0));
  endtask

  // main sequence
  initial begin
    logic [W-1:0] tail_word;
    int target;
    tail_word = {80'h0, 48'hFFFF_FFFF_FFFF};

    // reset held, then released
    repeat (3) @(negedge pixclk_in);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    repeat (2) @(negedge pixclk_in);
    check_reset_outputs("rst_release");

    // one 640-pixel line: five bursts of 16 at 0x000..0x400
    ack_delay = 2;
    ready_mode = 0;
    line_len_q.push_back(640);
    run_frame(1'b0);

    // 643 white pixels: last word holds three pixels
    line_len_q.push_back(643);
    run_frame(1'b1);
    check("tail_word", last_beat, tail_word);

    // 320 pixels: 16,16,8 then next frame starts at FRAME_BASE
    line_len_q.push_back(320);
    run_frame(1'b0);
    line_len_q.push_back(128);
    run_frame(1'b0);
    check("next_frame_addr", W'(last_ack_addr), W'(FRAME_BASE));
    check("next_frame_len", W'(last_ack_len), W'(16));

    // overflow: ack held low, 65 words, only the first 64 survive
    ack_enable = 1'b0;
    send_vs_wait();
    line_len_q.push_back(520);
    plan_frame(1'b0, 64);
    drive_frame_lines();
    repeat (4) @(negedge pixclk_in);
    check("overflow_set", W'(overflow), W'(1));
    check("overflow_req_held", W'(bus.wr_req), W'(1));
    target = fd_cnt + 1;
    @(negedge pixclk_in);
    vs_in = 1'b1;
    @(negedge pixclk_in);
    check("overflow_cleared", W'(overflow), W'(0));
    @(negedge pixclk_in);
    vs_in = 1'b0;
    ack_enable = 1'b1;
    wait_fd(target);
    check_drained("overflow");

    // wr_ready toggling every cycle
    ready_mode = 1;
    line_len_q.push_back(300);
    line_len_q.push_back(200);
    run_frame(1'b0);

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      ready_mode = $urandom_range(0, 2);
      ack_delay = $urandom_range(0, 4);
      for (int l = 0; l < int'($urandom_range(1, 3)); l++) line_len_q.push_back($urandom_range(1, 400));
      run_frame(1'b0);
    end

    // asynchronous reset in the middle of a data burst
    ready_mode = 0;
    ack_delay = 1;
    send_vs_wait();
    ack_enable = 1'b0;
    line_len_q.push_back(256);
    plan_frame(1'b0, 1 << 20);
    drive_frame_lines();
    ack_enable = 1'b1;
    for (int c = 0; c < 200 && !bus.wr_valid; c++) @(negedge pixclk_in);
    check("reached_data", W'(bus.wr_valid), W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    exp_q.delete();
    exp_addr_q.delete();
    exp_len_q.delete();
    repeat (2) @(negedge pixclk_in);
    rst_n = 1'b1;
    @(negedge pixclk_in);
    check_reset_outputs("rst_after_data");
    send_vs_wait();
    repeat (40) @(negedge pixclk_in);
    check("post_reset_valid", W'(bus.wr_valid), W'(0));
    check_drained("post_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/video_wr_packer.md
Name: video_wr_packer

Overview:
Downstream stage of the HDMI input scaler. It consumes the scaled pixel stream (vs/de/24-bit RGB) and converts each pixel to RGB565. It packs 8 pixels into 128-bit words, buffers the words in an internal FIFO, and issues burst write requests to the DDR write arbiter. It also generates the per-frame address reset and a frame-done pulse.

Parameters:
FRAME_BASE, 28'h000_0000, byte address of frame start
BURST_LEN, 16, words per full burst (power of 2, ≤ 128)
FIFO_DEPTH, 64, word FIFO depth (power of 2, ≥ 2*BURST_LEN)
ADDR_W, 28, write address width

Ports:
pixclk_in  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
vs_in  in  1  frame sync, active high; rising edge = frame boundary
de_in  in  1  pixel valid
data_in  in  24  {R[7:0],G[7:0],B[7:0]}, sampled when de_in=1
wr_req  out  1  burst request, held until wr_ack
wr_addr  out  ADDR_W  burst byte address, stable while wr_req=1
wr_len  out  8  burst length in words, stable while wr_req=1
wr_ack  in  1  one-cycle accept of request
wr_valid  out  1  write data valid
wr_data  out  128  write data word
wr_ready  in  1  arbiter accepts the word when wr_valid&wr_ready
frame_done  out  1  one-cycle pulse when the frame's last word is written
overflow  out  1  sticky; a word was dropped because the FIFO was full

Behaviour:
- Reset (async, rst_n=0): wr_req=0, wr_addr=FRAME_BASE, wr_len=0, wr_valid=0, wr_data=0, frame_done=0, overflow=0, FIFO empty, pack index=0, state IDLE, pending=0.
- Conversion: pix565 = {R[7:3],G[7:2],B[7:3]}. Pixel k of a word (k=0..7) occupies bits [16k+15:16k]; pixel 0 is the first in time.
- Packing: each de_in=1 cycle writes pix565 to slot idx, then idx++.
  - When idx reaches 7, the word is pushed one cycle later and idx returns to 0.
- Line end: a falling edge of de_in (registered de_in_1d & ~de_in) with idx≠0 pushes the partial word, unfilled slots zero, and sets idx=0. With idx=0, nothing is pushed.
- Frame edge: on a rising edge of vs_in, set pending=1 and clear overflow.
  - If a partial word is held, it is pushed first, as at line end.
- FIFO push when full: the word is dropped and overflow=1. A push and a pop in the same cycle when full succeeds.
- FSM states IDLE, REQ, DATA.
  - IDLE, fifo_count ≥ BURST_LEN: wr_len=BURST_LEN, go to REQ. This has priority over pending.
  - IDLE, pending=1 and 0<fifo_count<BURST_LEN: wr_len=fifo_count (sampled now), go to REQ.
  - IDLE, pending=1 and fifo_count=0: wr_addr=FRAME_BASE, pending=0, frame_done=1 for one cycle, stay in IDLE.
  - REQ: wr_req=1. On wr_ack, wr_req=0 next cycle and go to DATA with beat counter=0.
  - DATA: wr_valid=1 whenever the FIFO is non-empty; wr_data is the FIFO head (show-ahead). Each wr_valid&wr_ready pops one word and increments the beat counter.
  - DATA exit: after the wr_len-th beat, wr_valid=0 in the next cycle, wr_addr += wr_len*16 (mod 2^ADDR_W), go to IDLE.
- wr_valid never asserts outside DATA, and never asserts for more than wr_len beats per burst.
- Pixels arriving during REQ or DATA continue to be packed and pushed. Pixels of the new frame that arrive before the flush completes are written after the address reset.
- Minimum latency: 8th pixel to wr_req is 3 cycles (store, push, IDLE decision) when the FIFO reaches BURST_LEN.

Test Plan:
1. Hold rst_n=0, then release → all outputs at reset values; wr_addr=FRAME_BASE. Assert rst_n=0 mid-DATA → outputs return to reset values asynchronously, FIFO empty.
2. vs rise, then one 640-pixel line, wr_ack after 2 cycles, wr_ready=1 → 5 bursts of len 16 at addresses 0x000, 0x100, 0x200, 0x300, 0x400. Then frame_done after a second vs rise.
3. Line of 643 pixels with data_in=24'hFFFFFF → 81 words. Word 80 = 80'h0 followed by 48'hFFFF_FFFF_FFFF in bits [47:0], upper bits zero.
4. 320 pixels (40 words), then vs rise → bursts of 16, 16, 8; frame_done pulse; the next frame's first burst is at FRAME_BASE.
5. wr_ack held low, 65 words pushed → 64 retained, overflow=1. Next vs rise → overflow=0, the retained words drain in order.
6. wr_ready toggled 1/0 every cycle during DATA → exactly wr_len beats, data in FIFO order, no beat lost or duplicated.
